uart_rx_word: RTL

UART_RX_WORD -- requirements
Module: uart_rx_word

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx_word.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default line settings,
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 12 MHz system clock at 9600 baud, 8 data bits, 2 stop bits
    localparam int UART_DEF_BAUD_RATIO = 1250;
    localparam int UART_DEF_DATA_BITS  = 8;
    localparam int UART_DEF_STOP_BITS  = 2;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both stages
// reset to 1 so an idle-high line looks idle straight out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver that assembles several characters (first one in the LSBs)
// into one output word, with frame-error reporting and inter-character timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a falling edge (or break re-arm)
//   ST_START | half a bit in; confirm start bit is still low
//   ST_DATA  | sample data bits LSB-first, one bit period apart
//   ST_STOP  | sample stop bits; any low sample marks the character bad
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int BAUD_2_CLOCK_RATIO  = UART_DEF_BAUD_RATIO,
    parameter int UART_DATA_BITS      = UART_DEF_DATA_BITS,
    parameter int UART_STOP_BITS      = UART_DEF_STOP_BITS,
    parameter int OUTPUT_DATA_WIDTH   = 16,
    parameter int WORD_TIMEOUT_CLOCKS = 12000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx,
    output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
    output logic                         data_valid,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int NUM_CHARS = OUTPUT_DATA_WIDTH / UART_DATA_BITS;
    localparam int TW = clog2_min1(BAUD_2_CLOCK_RATIO);
    localparam int BW = clog2_min1(max_int(UART_DATA_BITS, UART_STOP_BITS));
    localparam int IW = clog2_min1(NUM_CHARS);
    localparam int OW = clog2_min1(WORD_TIMEOUT_CLOCKS);

    localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_2_CLOCK_RATIO / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(BAUD_2_CLOCK_RATIO - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(UART_STOP_BITS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CHARS - 1);
    localparam logic [OW-1:0] TMO_LOAD  = OW'(WORD_TIMEOUT_CLOCKS - 1);

    logic rx_s;

    uart_state_e                  state_q, state_d;
    logic [TW-1:0]                tmr_q, tmr_d;
    logic [BW-1:0]                bit_q, bit_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [OW-1:0]                tmo_q, tmo_d;
    logic [UART_DATA_BITS-1:0]    shift_q, shift_d;
    logic [OUTPUT_DATA_WIDTH-1:0] word_q, word_d;
    logic [OUTPUT_DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                         data_valid_q, data_valid_d;
    logic                         frame_err_q, frame_err_d;
    logic                         bad_q, bad_d;
    logic                         brk_q, brk_d;
    logic                         rx_prev_q, rx_prev_d;

    logic                         rx_fall;
    logic                         tick;
    logic                         bad_now;
    logic [OUTPUT_DATA_WIDTH-1:0] word_ins;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        bit_d        = bit_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        shift_d      = shift_q;
        word_d       = word_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        bad_d        = bad_q;
        brk_d        = brk_q;
        rx_prev_d    = rx_s;

        rx_fall  = rx_prev_q & ~rx_s;
        tick     = (tmr_q == '0);
        bad_now  = bad_q | ~rx_s;
        word_ins = word_q;
        word_ins[int'(idx_q)*UART_DATA_BITS +: UART_DATA_BITS] = shift_q;

        unique case (state_q)
            ST_IDLE: begin
                // A held-low break never produces a new falling edge, so a
                // break character re-arms reception while the line stays low.
                if (rx_fall || (brk_q && !rx_s)) begin
                    state_d = ST_START;
                    tmr_d   = HALF_LOAD;
                    bit_d   = '0;
                    brk_d   = 1'b0;
                end else if (rx_s) begin
                    brk_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        tmr_d   = FULL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = (shift_q >> 1) |
                              (UART_DATA_BITS'(rx_s) << (UART_DATA_BITS - 1));
                    tmr_d   = FULL_LOAD;
                    if (bit_q == DATA_LAST) begin
                        state_d = ST_STOP;
                        bit_d   = '0;
                        bad_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tmr_d = FULL_LOAD;
                    if (bit_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                        bad_d   = 1'b0;
                        if (bad_now) begin
                            frame_err_d = 1'b1;
                            idx_d       = '0;
                            brk_d       = (shift_q == '0) && !rx_s;
                        end else if (idx_q == IDX_LAST) begin
                            data_out_d   = word_ins;
                            data_valid_d = 1'b1;
                            idx_d        = '0;
                        end else begin
                            word_d = word_ins;
                            idx_d  = idx_q + IW'(1);
                        end
                    end else begin
                        bad_d = bad_now;
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Partial word is dropped silently if the next character is too late.
        if ((state_q == ST_IDLE) && (idx_q != '0)) begin
            if (tmo_q == '0) begin
                idx_d = '0;
                tmo_d = TMO_LOAD;
            end else begin
                tmo_d = tmo_q - OW'(1);
            end
        end else begin
            tmo_d = TMO_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            bit_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            bad_q        <= 1'b0;
            brk_q        <= 1'b0;
            rx_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            bad_q        <= bad_d;
            brk_q        <= brk_d;
            rx_prev_q    <= rx_prev_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
